product_accum_register: RTL
===========================

Name: product_accum_register

Overview:
- Parametrised successor to the plain product register bank.
- Holds a DIM_C x DIM_A array of ACC_WIDTH product accumulators.
- Accumulates a runtime-configured number of input beats per tile, with per-lane masking and saturating or wrapping arithmetic.
- Presents the finished tile on a valid/ready output handshake. Sits between the LUT multiplier array and the output writeback stage.

Parameters:
- DIM_C, 2, outer (channel) dimension of the product array.
- DIM_A, 2, inner dimension of the product array.
- IN_WIDTH, 8, signed width of each incoming product.
- ACC_WIDTH, 12, signed accumulator width. Must be >= IN_WIDTH; elaboration error otherwise.
- LEN_W, 8, width of the beat-count configuration.
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort/flush, highest priority.
- cfg_len  in  LEN_W  beats per tile; sampled on the first beat of a tile only.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  [DIM_C][DIM_A][IN_WIDTH]  signed products.
- in_lane_en  in  [DIM_C][DIM_A]  per-lane enable; 0 = lane contributes zero this beat.
- out_valid  out  1  tile result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  [DIM_C][DIM_A][ACC_WIDTH]  registered accumulators.
- out_ovf  out  [DIM_C][DIM_A]  sticky per-lane overflow flag for the current tile.
- beat_cnt  out  LEN_W  beats accepted in the current tile.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; acc, out_ovf, beat_cnt, len_q all 0; out_valid=0; in_ready=1.
- Lane operand:
  - in_lane_en[c][a]=1: operand is in_data[c][a] sign-extended to ACC_WIDTH.
  - in_lane_en[c][a]=0: operand is 0.
- Sum: computed at ACC_WIDTH+1 bits. On signed overflow:
  - SATURATE=1: clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: keep low ACC_WIDTH bits.
  - Either mode: set out_ovf for that lane.
- States and transitions:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On accept: acc <= operand (no add); out_ovf <= 0; len_q <= (cfg_len==0 ? 1 : cfg_len); beat_cnt <= 1.
    - Go to HOLD if effective len==1, else ACCUM.
  - ACCUM:
    - in_ready=1, out_valid=0.
    - On accept: acc <= acc+operand; beat_cnt++.
    - Go to HOLD when new beat_cnt==len_q.
    - No accept: hold all state.
  - HOLD:
    - out_valid=1; out_data=acc, stable while out_ready=0.
    - in_ready = out_ready (combinational).
    - out_ready=1 and no in_valid: go to IDLE; beat_cnt <= 0.
    - out_ready=1 and in_valid=1 on the same cycle: result consumed and the new tile's first beat loaded exactly as in IDLE, on the same edge. No bubble.
- Latency: out_valid rises the cycle after the final beat is accepted.
- clear:
  - In any state, next edge: IDLE, acc=0, out_ovf=0, beat_cnt=0, out_valid=0.
  - in_ready=0 during a cycle with clear=1; no beat is accepted.
  - A pending HOLD result is discarded.
- cfg_len changes mid-tile: ignored until the next tile's first beat.
- Reset mid-tile: immediate return to reset values; partial tile lost.
- out_data, out_ovf and beat_cnt are driven directly from registers.

Test Plan:
All scenarios use defaults: DIM_C=DIM_A=2, IN_WIDTH=8, ACC_WIDTH=12, all lanes enabled unless stated.
- Reset: assert rst_n low mid-ACCUM with acc nonzero. Required: out_valid=0, out_data all 0, out_ovf 0, beat_cnt 0, in_ready=1 immediately, without waiting for a clock edge.
- Basic tile: cfg_len=3, beats of 5, 6, 7 in all lanes back-to-back. Required: out_valid=1 the cycle after the 3rd beat, every lane 18, out_ovf=0, beat_cnt=3. cfg_len=0 with one beat of 9 gives a result of 9 after one beat.
- Overflow, cfg_len=20:
  - Beats of 127, SATURATE=1: every lane 2047, ovf=1.
  - Beats of -128, SATURATE=1: every lane -2048, ovf=1.
  - Beats of 127, SATURATE=0: every lane -1556, ovf=1.
- Backpressure: result 18 in HOLD, out_ready=0 for 5 cycles with in_valid=1. Required:
  - out_data stable at 18 and in_ready=0 throughout; no beat accepted.
  - Then out_ready=1, in_valid=1, cfg_len=1, data 4. Required: out_valid stays 1 and out_data=4 on the next cycle.
- Lane mask: cfg_len=2, beats of 10 then 20.
  - in_lane_en={1,0,1,0} on beat 1, all 1 on beat 2.
  - Required: enabled lanes 30, masked lanes 20.
- Clear mid-tile: cfg_len=4, clear after 2 beats of 50.
  - Required: IDLE next cycle, out_valid=0, beat_cnt=0.
  - A following cfg_len=1 tile with data 3 gives 3 with ovf=0.

Source files
------------

// File: rtl/product_accum_register.sv
// Product accumulator bank: sums a configurable number of masked product
// beats per tile into a DIM_C x DIM_A array and hands the tile downstream
// on a valid/ready handshake.
module product_accum_register #(
  parameter int unsigned DIM_C     = 2,
  parameter int unsigned DIM_A     = 2,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned LEN_W     = 8,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clear,
  input  logic [LEN_W-1:0]                              cfg_len,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DIM_C-1:0][DIM_A-1:0][IN_WIDTH-1:0]     in_data,
  input  logic [DIM_C-1:0][DIM_A-1:0]                   in_lane_en,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    out_data,
  output logic [DIM_C-1:0][DIM_A-1:0]                   out_ovf,
  output logic [LEN_W-1:0]                              beat_cnt
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Accumulators narrower than the products cannot hold a single beat.
  if (ACC_WIDTH < IN_WIDTH) begin : g_width_check
    $error("product_accum_register: ACC_WIDTH must be >= IN_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                                        state_q, state_d;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [DIM_C-1:0][DIM_A-1:0]                   ovf_q, ovf_d;
  logic [LEN_W-1:0]                              beat_q, beat_d;
  logic [LEN_W-1:0]                              len_q, len_d;
  logic                                          out_valid_q, out_valid_d;

  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    oper_c;
  logic [DIM_C-1:0][DIM_A-1:0][SUM_W-1:0]        sum_c;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    add_c;
  logic [DIM_C-1:0][DIM_A-1:0]                   add_ovf_c;
  logic [LEN_W-1:0]                              eff_len_c;
  logic                                          accept_c;

  // A beat is never taken while flushing; in HOLD it needs the result to drain.
  assign in_ready  = !clear && ((state_q != ST_HOLD) || out_ready);
  assign accept_c  = in_valid && in_ready;
  assign eff_len_c = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  // Per-lane operand select, widened add and overflow resolution.
  always_comb begin
    oper_c    = '0;
    sum_c     = '0;
    add_c     = '0;
    add_ovf_c = '0;
    for (int unsigned c = 0; c < DIM_C; c++) begin
      for (int unsigned a = 0; a < DIM_A; a++) begin
        oper_c[c][a] = in_lane_en[c][a] ? ACC_WIDTH'($signed(in_data[c][a])) : '0;
        sum_c[c][a]  = SUM_W'($signed(acc_q[c][a])) + SUM_W'($signed(oper_c[c][a]));
        add_ovf_c[c][a] = sum_c[c][a][SUM_W-1] ^ sum_c[c][a][SUM_W-2];
        if (add_ovf_c[c][a] && SATURATE) begin
          add_c[c][a] = sum_c[c][a][SUM_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
          add_c[c][a] = sum_c[c][a][ACC_WIDTH-1:0];
        end
      end
    end
  end

  // Tile sequencing: first-beat load, accumulate, hold for the consumer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    beat_d  = beat_q;
    len_d   = len_q;
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = '0;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            acc_d  = add_c;
            ovf_d  = ovf_q | add_ovf_c;
            beat_d = beat_q + LEN_W'(1);
            if (beat_d == len_q) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready && !in_valid) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end
        end
        default: ;
      endcase
      // First beat of a tile, from IDLE or back-to-back out of HOLD.
      if (accept_c && (state_q != ST_ACCUM)) begin
        acc_d   = oper_c;
        ovf_d   = '0;
        len_d   = eff_len_c;
        beat_d  = LEN_W'(1);
        state_d = (eff_len_c == LEN_W'(1)) ? ST_HOLD : ST_ACCUM;
      end
    end
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign beat_cnt  = beat_q;

endmodule
